// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller/datapath pair:
// ALU operation codes, mux select enums and instruction field positions.
package mc_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  localparam int REG_ADDR_W = 5;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int JADDR_MSB = 25;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, r0 hardwired to zero.
module regfile
  import mc_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [31:0]           wd,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [31:0]           rd1,
  output logic [31:0]           rd2
);

  logic [31:0] mem [32];

  // NOTE: the array has no reset branch on purpose; resetting 32 words costs a
  // reset tree on every bit and forces flops where a RAM macro would do.
  always_ff @(posedge clk) begin
    if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR/MDR/A/B/ALUOut, register file, ALU and the
// memory address/write-data muxes, steered entirely by the controller strobes.
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcen,
  input  logic        irwrite,
  input  logic        regwrite,
  input  logic        alusrca,
  input  logic        iord,
  input  logic        memtoreg,
  input  logic        regdst,
  input  logic [1:0]  alusrcb,
  input  logic [1:0]  pcsrc,
  input  logic [2:0]  alucontrol,
  input  logic [31:0] readdata,
  output logic [31:0] adr,
  output logic [31:0] writedata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;

  logic [31:0] rd1, rd2;
  logic [31:0] sign_imm, jump_target;
  logic [31:0] src_a, src_b, alu_result, pc_next, rf_wd;
  logic [REG_ADDR_W-1:0] rf_wa;
  logic        rf_we;
  alusrcb_e    srcb_sel;
  pcsrc_e      pc_sel;

  assign srcb_sel    = alusrcb_e'(alusrcb);
  assign pc_sel      = pcsrc_e'(pcsrc);
  assign sign_imm    = sign_ext16(ir_q[IMM_MSB:0]);
  assign jump_target = {pc_q[31:28], ir_q[JADDR_MSB:0], 2'b00};

  assign rf_wa = regdst ? ir_q[RD_MSB:RD_LSB] : ir_q[RT_MSB:RT_LSB];
  assign rf_wd = memtoreg ? mdr_q : aluout_q;
  // Reset must win over a coincident write-back so no half-retired result lands.
  assign rf_we = regwrite && !reset;

  regfile u_regfile (
    .clk (clk),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd),
    .ra1 (ir_q[RS_MSB:RS_LSB]),
    .ra2 (ir_q[RT_MSB:RT_LSB]),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    src_a = alusrca ? a_q : pc_q;
    src_b = b_q;
    case (srcb_sel)
      SRCB_REG:     src_b = b_q;
      SRCB_FOUR:    src_b = 32'd4;
      SRCB_IMM:     src_b = sign_imm;
      SRCB_IMM_SH2: src_b = sign_imm << 2;
      default:      src_b = b_q;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alucontrol)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'b0, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    pc_next = pc_q;
    case (pc_sel)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = aluout_q;
      PCSRC_JUMP:   pc_next = jump_target;
      PCSRC_HOLD:   pc_next = pc_q;
      default:      pc_next = pc_q;
    endcase
  end

  always_comb begin
    pc_d     = pcen ? pc_next : pc_q;
    ir_d     = irwrite ? readdata : ir_q;
    mdr_d    = readdata;
    a_d      = rd1;
    b_d      = rd2;
    aluout_d = alu_result;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  assign adr       = iord ? aluout_q : pc_q;
  assign writedata = b_q;
  assign op        = ir_q[OP_MSB:OP_LSB];
  assign funct     = ir_q[FUNCT_MSB:FUNCT_LSB];
  assign zero      = (alu_result == '0);

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the DUT ports.
module tb_mc_datapath;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata, adr, writedata;
  logic [5:0]  op, funct;
  logic        zero;

  always #5 clk = ~clk;

  mc_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .readdata   (readdata),
    .adr        (adr),
    .writedata  (writedata),
    .op         (op),
    .funct      (funct),
    .zero       (zero)
  );

  typedef enum {K_ADR, K_WD, K_OP, K_FUNCT, K_ZERO} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Expectations describe the cycle whose controls are currently applied;
  // they are compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_ADR:   act = adr;
        K_WD:    act = writedata;
        K_OP:    act = {26'b0, op};
        K_FUNCT: act = {26'b0, funct};
        default: act = {31'b0, zero};
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input kind_e k, input string nm, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.name = nm;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PCSRC_HOLD;
    alucontrol = ALU_ADD;
    readdata   = '0;
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle();
    irwrite  = 1'b1;
    alusrcb  = SRCB_FOUR;
    pcsrc    = PCSRC_ALU;
    pcen     = 1'b1;
    readdata = instr;
  endtask

  task automatic decode();
    idle();
    alusrcb = SRCB_IMM_SH2;
    cyc();
  endtask

  // Run one ALU op with A = PC, then read ALUOut back through adr.
  task automatic alu_chk(input logic [2:0] ctl, input alusrcb_e sb, input logic [31:0] v,
                         input string nm);
    idle();
    alucontrol = ctl;
    alusrcb    = sb;
    expect_v(K_ZERO, {nm, "_zero"}, {31'b0, (v == 32'd0)});
    cyc();
    idle();
    iord = 1'b1;
    expect_v(K_ADR, nm, v);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;

    expect_v(K_ADR,   "reset_adr",   32'h0);
    expect_v(K_OP,    "reset_op",    32'h0);
    expect_v(K_FUNCT, "reset_funct", 32'h0);
    expect_v(K_ZERO,  "reset_zero",  32'h1);
    cyc();

    // lw $9,4($0) at PC=0
    fetch(32'h8C09_0004);
    expect_v(K_ADR, "lw_fetch_adr", 32'h0);
    cyc();
    idle();
    expect_v(K_OP,    "lw_op",    32'h23);
    expect_v(K_FUNCT, "lw_funct", 32'h04);
    alusrcb = SRCB_IMM_SH2;
    cyc();
    idle();
    alusrca = 1'b1;
    alusrcb = SRCB_IMM;
    expect_v(K_ZERO, "lw_addr_zero", 32'h0);
    cyc();
    iord     = 1'b1;
    readdata = 32'h1234_5678;
    expect_v(K_ADR, "lw_mem_adr", 32'h4);
    cyc();
    idle();
    memtoreg = 1'b1;
    regwrite = 1'b1;
    cyc();

    // sw $9,8($0) at PC=4
    fetch(32'hAC09_0008);
    expect_v(K_ADR, "sw_fetch_adr", 32'h4);
    cyc();
    decode();
    idle();
    alusrca = 1'b1;
    alusrcb = SRCB_IMM;
    expect_v(K_WD, "sw_b_reg", 32'h1234_5678);
    cyc();
    iord = 1'b1;
    expect_v(K_ADR, "sw_mem_adr", 32'h8);
    expect_v(K_WD,  "sw_mem_wd",  32'h1234_5678);
    cyc();

    // beq $9,$9,+3 at PC=8: taken
    fetch(32'h1129_0003);
    expect_v(K_ADR, "beq_fetch_adr", 32'h8);
    cyc();
    idle();
    expect_v(K_OP, "beq_op", 32'h04);
    alusrcb = SRCB_IMM_SH2;
    cyc();
    idle();
    alusrca    = 1'b1;
    alucontrol = ALU_SUB;
    iord       = 1'b1;
    pcsrc      = PCSRC_ALUOUT;
    pcen       = 1'b1;
    expect_v(K_ADR,  "beq_target_aluout", 32'd24);
    expect_v(K_ZERO, "beq_eq_zero",       32'h1);
    cyc();

    // beq $9,$0,+3 at PC=24: not taken
    fetch(32'h1120_0003);
    expect_v(K_ADR, "beq_taken_pc", 32'd24);
    cyc();
    decode();
    idle();
    alusrca    = 1'b1;
    alucontrol = ALU_SUB;
    pcsrc      = PCSRC_ALUOUT;
    expect_v(K_ZERO, "beq_ne_zero", 32'h0);
    cyc();

    // j 0x10 at PC=28
    fetch(32'h0800_0010);
    expect_v(K_ADR, "beq_not_taken_pc", 32'd28);
    cyc();
    idle();
    pcsrc = PCSRC_JUMP;
    pcen  = 1'b1;
    expect_v(K_OP, "j_op", 32'h02);
    cyc();
    idle();
    pcsrc = PCSRC_HOLD;
    pcen  = 1'b1;
    expect_v(K_ADR, "j_target_pc", 32'h40);
    cyc();

    // add $0,$9,$9 at PC=0x40
    fetch(32'h0129_0020);
    expect_v(K_ADR, "pcsrc_hold_pc", 32'h40);
    cyc();
    idle();
    expect_v(K_FUNCT, "add_funct", 32'h20);
    alusrcb = SRCB_IMM_SH2;
    cyc();
    idle();
    alusrca = 1'b1;
    expect_v(K_ZERO, "add_exec_zero", 32'h0);
    cyc();
    regdst   = 1'b1;
    regwrite = 1'b1;
    cyc();

    // sw $0,0($0) at PC=0x44 reads r0 into A and B
    fetch(32'hAC00_0000);
    expect_v(K_ADR, "sw0_fetch_adr", 32'h44);
    cyc();
    decode();
    idle();
    alusrca = 1'b1;
    expect_v(K_ZERO, "r0_a_plus_b_zero", 32'h1);
    expect_v(K_WD,   "r0_b_reg",         32'h0);
    cyc();

    // lw $9 fetch, then reset with a coincident write-back to $9
    fetch(32'h8C09_0004);
    expect_v(K_ADR, "lw2_fetch_adr", 32'h48);
    cyc();
    idle();
    reset    = 1'b1;
    regwrite = 1'b1;
    cyc();
    reset = 1'b0;

    // sw $9,-4($0) at PC=0 after reset
    fetch(32'hAC09_FFFC);
    expect_v(K_ADR, "post_reset_adr", 32'h0);
    expect_v(K_OP,  "post_reset_op",  32'h0);
    cyc();
    decode();
    expect_v(K_WD, "r9_kept_over_reset", 32'h1234_5678);

    // ALU sweep with A = PC = 4, SignImm = -4, B = 0x12345678
    alu_chk(ALU_ADD, SRCB_IMM,     32'h0000_0000, "alu_add_imm");
    alu_chk(ALU_SUB, SRCB_IMM,     32'h0000_0008, "alu_sub_imm");
    alu_chk(ALU_AND, SRCB_IMM,     32'h0000_0004, "alu_and_imm");
    alu_chk(ALU_OR,  SRCB_IMM,     32'hFFFF_FFFC, "alu_or_imm");
    alu_chk(ALU_SLT, SRCB_IMM,     32'h0000_0000, "alu_slt_signed");
    alu_chk(ALU_SLT, SRCB_REG,     32'h0000_0001, "alu_slt_true");
    alu_chk(3'b011,  SRCB_IMM,     32'h0000_0000, "alu_code_011");
    alu_chk(ALU_ADD, SRCB_IMM_SH2, 32'hFFFF_FFF4, "alu_add_imm_sh2");
    alu_chk(ALU_ADD, SRCB_FOUR,    32'h0000_0008, "alu_add_four");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
